// File: rtl/mc_datapath.sv
// Multicycle 16-bit-instruction datapath with a DW-wide register file and a shared memory port.
// Define MC_DATAPATH_FASTBR_EN to resolve jump/branch in DECODE instead of EXEC.
module mc_datapath #(
   parameter int            DW       = 16,
   parameter logic [DW-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          reset,
   output logic [15:0]   instr,
   input  logic          memtoreg,
   input  logic          memwrite,
   input  logic          alusrc,
   input  logic          regdst,
   input  logic          regwrite,
   input  logic          jump,
   input  logic          branch,
   input  logic [2:0]    alucontrol,
   output logic          mem_req,
   output logic          mem_we,
   output logic [DW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic [DW-1:0] pc,
   output logic [2:0]    state,
   output logic          zero,
   output logic          less,
   output logic          retire
);

   typedef enum logic [2:0] {
      BOOT   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5
   } state_t;

   state_t        st, st_nxt;
   logic          retire_nxt;
   logic [DW-1:0] a, b, alu_out, mdr;
   logic [DW-1:0] rf [8];
   logic          store_q;

   logic [2:0]    rs, rt, rd, wr_idx;
   logic [DW-1:0] rd_a, rd_b, signimm, srcb, alu_res;
   logic [DW-1:0] pc_plus2, br_tgt, jmp_tgt;
   logic          alu_lt;

   assign rs       = instr[12:10];
   assign rt       = instr[9:7];
   assign rd       = instr[2:0];
   assign wr_idx   = regdst ? rd : rt;
   assign rd_a     = rf[rs];
   assign rd_b     = rf[rt];
   assign signimm  = {{(DW-7){instr[6]}}, instr[6:0]};
   assign srcb     = alusrc ? signimm : b;
   assign pc_plus2 = pc + DW'(2);
   assign br_tgt   = pc_plus2 + {signimm[DW-2:0], 1'b0};
   assign jmp_tgt  = {pc_plus2[DW-1:13], instr[12:1], 1'b0};
   assign alu_lt   = $signed(a) < $signed(srcb);
   assign state    = st;

   always_comb begin
      alu_res = '0;
      case (alucontrol)
         3'b000:  alu_res = a & srcb;
         3'b001:  alu_res = a | srcb;
         3'b010:  alu_res = a + srcb;
         3'b110:  alu_res = a - srcb;
         3'b111:  alu_res = {{(DW-1){1'b0}}, alu_lt};
         default: alu_res = '0;
      endcase
   end

   // Memory port driven only from state and registers, so no input reaches it combinationally.
   assign mem_req   = (st == FETCH) || (st == MEM);
   assign mem_we    = (st == MEM) && store_q;
   assign mem_addr  = (st == MEM) ? alu_out : pc;
   assign mem_wdata = b;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) st <= BOOT;
      else        st <= st_nxt;
   end

   always_comb begin
      st_nxt     = BOOT;
      retire_nxt = 1'b0;
      case (st)
         BOOT:   st_nxt = FETCH;
         FETCH:  st_nxt = mem_ready ? DECODE : FETCH;
         DECODE: begin
            st_nxt = EXEC;
`ifdef MC_DATAPATH_FASTBR_EN
            if (jump || branch) begin
               st_nxt     = FETCH;
               retire_nxt = 1'b1;
            end
`endif
         end
         EXEC: begin
            if (jump || branch) begin
               st_nxt     = FETCH;
               retire_nxt = 1'b1;
            end else if (memtoreg || memwrite) begin
               st_nxt = MEM;
            end else begin
               st_nxt = WB;
            end
         end
         MEM: begin
            st_nxt = MEM;
            if (mem_ready) begin
               if (store_q) begin
                  st_nxt     = FETCH;
                  retire_nxt = 1'b1;
               end else begin
                  st_nxt = WB;
               end
            end
         end
         WB: begin
            st_nxt     = FETCH;
            retire_nxt = 1'b1;
         end
         default: st_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc      <= RESET_PC;
         instr   <= '0;
         a       <= '0;
         b       <= '0;
         alu_out <= '0;
         mdr     <= '0;
         zero    <= 1'b0;
         less    <= 1'b0;
         retire  <= 1'b0;
         store_q <= 1'b0;
         for (int i = 0; i < 8; i++) rf[i] <= '0;
      end else begin
         retire <= retire_nxt;
         case (st)
            FETCH: if (mem_ready) instr <= mem_rdata[15:0];
            DECODE: begin
               a <= rd_a;
               b <= rd_b;
`ifdef MC_DATAPATH_FASTBR_EN
               if (jump)        pc <= jmp_tgt;
               else if (branch) pc <= (rd_a == rd_b) ? br_tgt : pc_plus2;
`endif
            end
            EXEC: begin
               alu_out <= alu_res;
               zero    <= (alu_res == '0);
               less    <= alu_lt;
               store_q <= memwrite;
               if (jump)        pc <= jmp_tgt;
               else if (branch) pc <= (a == b) ? br_tgt : pc_plus2;
            end
            MEM: begin
               if (mem_ready) begin
                  if (store_q) pc  <= pc_plus2;
                  else         mdr <= mem_rdata;
               end
            end
            WB: begin
               // r0 is never written, which keeps it reading as zero.
               if (regwrite && wr_idx != 3'd0) rf[wr_idx] <= memtoreg ? mdr : alu_out;
               pc <= pc_plus2;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: DW=32 core running a short program, plus a DW=16 core looping a jump.
module tb_mc_datapath;

   localparam int DW = 32;
`ifdef MC_DATAPATH_FASTBR_EN
   localparam int BR_CYC = 2;
`else
   localparam int BR_CYC = 3;
`endif

   typedef struct packed {
      logic       memtoreg, memwrite, alusrc, regdst, regwrite, jump, branch;
      logic [2:0] alucontrol;
   } ctl_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // main core
   logic [15:0]   instr;
   ctl_t          c1;
   logic          mem_req, mem_we, mem_ready, zero, less, retire;
   logic [DW-1:0] mem_addr, mem_wdata, mem_rdata, pc;
   logic [2:0]    state;

   // DW=16 core at 0xE000
   logic [15:0]   instr2, mem_addr2, mem_wdata2, pc2;
   ctl_t          c2;
   logic          mem_req2, mem_we2, zero2, less2, retire2;
   logic [2:0]    state2;

   int n_chk = 0;
   int n_pass = 0;

   function automatic ctl_t dec(input logic [15:0] i);
      ctl_t c = '0;
      case (i[15:13])
         3'b000: begin c.regdst = 1'b1; c.regwrite = 1'b1; c.alucontrol = i[5:3]; end
         3'b001: begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.alucontrol = 3'b010; end
         3'b010: begin c.alusrc = 1'b1; c.memtoreg = 1'b1; c.regwrite = 1'b1; c.alucontrol = 3'b010; end
         3'b011: begin c.alusrc = 1'b1; c.memwrite = 1'b1; c.alucontrol = 3'b010; end
         3'b100: begin c.branch = 1'b1; c.alucontrol = 3'b110; end
         3'b101: c.jump = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

   function automatic logic [15:0] ri(input logic [2:0] rs, rt, rd, f);
      return {3'b000, rs, rt, 1'b0, f, rd};
   endfunction
   function automatic logic [15:0] ii(input logic [2:0] op, rs, rt, input logic [6:0] imm);
      return {op, rs, rt, imm};
   endfunction
   function automatic logic [15:0] jj(input logic [11:0] t);
      return {3'b101, t, 1'b0};
   endfunction

   assign c1 = dec(instr);
   assign c2 = dec(instr2);

   mc_datapath #(.DW(DW), .RESET_PC(32'h0000_0040)) dut (
      .clk(clk), .reset(reset), .instr(instr),
      .memtoreg(c1.memtoreg), .memwrite(c1.memwrite), .alusrc(c1.alusrc), .regdst(c1.regdst),
      .regwrite(c1.regwrite), .jump(c1.jump), .branch(c1.branch), .alucontrol(c1.alucontrol),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc), .state(state),
      .zero(zero), .less(less), .retire(retire)
   );

   mc_datapath #(.DW(16), .RESET_PC(16'hE000)) dut2 (
      .clk(clk), .reset(reset), .instr(instr2),
      .memtoreg(c2.memtoreg), .memwrite(c2.memwrite), .alusrc(c2.alusrc), .regdst(c2.regdst),
      .regwrite(c2.regwrite), .jump(c2.jump), .branch(c2.branch), .alucontrol(c2.alucontrol),
      .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
      .mem_rdata(16'hB578), .mem_ready(1'b1), .pc(pc2), .state(state2),
      .zero(zero2), .less(less2), .retire(retire2)
   );

   // memory: word array indexed by addr[8:1], separate wait counts for fetch and data
   logic [DW-1:0] mem [256];
   int iwait = 0;
   int dwait = 0;
   int wcnt  = 0;
   assign mem_ready = mem_req && (wcnt >= ((state == 3'd4) ? dwait : iwait));
   assign mem_rdata = mem[mem_addr[8:1]];
   always @(posedge clk) begin
      if (mem_req && mem_ready) begin
         wcnt <= 0;
         if (mem_we) mem[mem_addr[8:1]] <= mem_wdata;
      end else if (mem_req) wcnt <= wcnt + 1;
      else                  wcnt <= 0;
   end

   int            we_cnt = 0;
   logic [DW-1:0] we_addr = '0, we_data = '0;
   always @(negedge clk) begin
      if (mem_req && mem_we) begin
         we_cnt  <= we_cnt + 1;
         we_addr <= mem_addr;
         we_data <= mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // Advance to the next retire pulse of the selected core; returns cycles taken.
   task automatic step(input bit sel, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(sel ? retire2 : retire) && cyc < 100);
   endtask

   task automatic put(input int idx, input logic [15:0] w);
      mem[idx] = {{(DW-16){1'b0}}, w};
   endtask

   initial begin
      int c, k, w0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      put(32, ii(3'b001, 3'd0, 3'd1, 7'd5));      // 0x40 addi r1,r0,5
      put(33, ri(3'd1, 3'd1, 3'd2, 3'b010));      // 0x42 add r2,r1,r1
      put(34, ri(3'd1, 3'd1, 3'd0, 3'b010));      // 0x44 add r0,r1,r1
      put(35, ii(3'b011, 3'd0, 3'd2, 7'h20));     // 0x46 sw r2,0x20(r0)
      put(36, ii(3'b010, 3'd0, 3'd3, 7'h20));     // 0x48 lw r3,0x20(r0)
      put(37, ii(3'b001, 3'd0, 3'd5, 7'd5));      // 0x4A addi r5,r0,5
      put(38, jj(12'h008));                       // 0x4C j -> 0x10
      put(8,  ii(3'b100, 3'd1, 3'd5, 7'h7E));     // 0x10 beq r1,r5,-2
      put(7,  ii(3'b001, 3'd0, 3'd5, 7'd7));      // 0x0E addi r5,r0,7
      put(9,  ii(3'b001, 3'd0, 3'd1, 7'h7F));     // 0x12 addi r1,r0,-1
      put(10, ri(3'd1, 3'd0, 3'd2, 3'b111));      // 0x14 slt r2,r1,r0
      put(11, ii(3'b011, 3'd0, 3'd2, 7'h22));     // 0x16 sw r2,0x22(r0)
      put(12, ii(3'b010, 3'd0, 3'd4, 7'h20));     // 0x18 lw r4,0x20(r0)

      reset = 1'b1;
      #3 reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_state", state, 3'd0);
      chk("rst_pc", pc, 32'h40);
      chk("rst_req", mem_req, 1'b0);
      chk("rst_retire", retire, 1'b0);
      chk("rst_flags", {zero, less}, 2'b00);
      chk("rst_instr", instr, 16'h0);

      reset = 1'b1;
      #1 chk("boot", state, 3'd0);
      @(negedge clk);
      chk("fetch_state", state, 3'd1);
      chk("fetch_addr", mem_addr, 32'h40);
      chk("fetch_req", {mem_req, mem_we}, 2'b10);

      step(0, c); chk("addi_cyc", c, 4); chk("r1_5", dut.rf[1], 32'd5);
      step(0, c); chk("add_cyc", c, 4); chk("r2_10", dut.rf[2], 32'd10); chk("add_zero", zero, 1'b0);
      step(0, c); chk("r0_keep", dut.rf[0], 32'd0);

      dwait = 3;
      w0 = we_cnt;
      step(0, c); chk("sw_cyc", c, 7);
      chk("sw_we_cycles", we_cnt - w0, 4);
      chk("sw_addr", we_addr, 32'h20);
      chk("sw_data", we_data, 32'd10);
      chk("sw_mem", mem[16], 32'd10);
      step(0, c); chk("lw_cyc", c, 8); chk("r3_10", dut.rf[3], 32'd10);
      dwait = 0;

      step(0, c);
      step(0, c); chk("j_cyc", c, BR_CYC); chk("j_pc", pc, 32'h10);
      step(0, c); chk("beq_t_cyc", c, BR_CYC); chk("beq_t_pc", pc, 32'h0E);
`ifndef MC_DATAPATH_FASTBR_EN
      chk("beq_zero", zero, 1'b1);
`endif
      step(0, c); chk("loop_pc", pc, 32'h10);
      step(0, c); chk("beq_nt_pc", pc, 32'h12);
      step(0, c); chk("r1_m1", dut.rf[1], 32'hFFFF_FFFF);
      step(0, c); chk("slt_r2", dut.rf[2], 32'd1); chk("slt_less", less, 1'b1);
      step(0, c); chk("sw2_mem", mem[17], 32'd1);

      dwait = 5;
      k = 0;
      while (state != 3'd4 && k < 20) begin @(negedge clk); k++; end
      chk("lw_in_mem", state, 3'd4);
      @(negedge clk);
      chk("lw_wait_req", mem_req, 1'b1);
      reset = 1'b0;
      #1 chk("rst_mid_req", mem_req, 1'b0);
      chk("rst_mid_state", state, 3'd0);
      @(negedge clk);
      chk("rst_mid_r4", dut.rf[4], 32'd0);
      chk("rst_mid_pc", pc, 32'h40);

      reset = 1'b1;
      @(negedge clk);
      chk("j16_fetch", {state2, pc2}, {3'd1, 16'hE000});
      step(1, c); chk("j16_cyc", c, BR_CYC); chk("j16_pc", pc2, 16'hF578);
      step(1, c); chk("j16_cyc2", c, BR_CYC); chk("j16_pc2", pc2, 16'hF578);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
